// File: rtl/elc3_kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package elc3_kbd_pkg;

    // Frame receiver states: start bit seen -> 8 data bits -> parity -> stop.
    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_DATA   = 2'd1,
        FS_PARITY = 2'd2,
        FS_STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // True for either shift key's scan code.
    function automatic logic is_shift(input logic [7:0] sc);
        return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational scan-code set 2 to ASCII lookup for letters, digits,
// space, enter and backspace. Shift only affects letters.
module ps2_scancode_to_ascii (
    input  logic [7:0] scan_code,
    input  logic       shift,
    output logic       valid,
    output logic [7:0] ascii
);

    // Table lookup, then fold lowercase letters to uppercase while shifted.
    always_comb begin
        valid = 1'b1;
        ascii = 8'h00;
        case (scan_code)
            8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            default: valid = 1'b0;
        endcase
        if (shift && (ascii >= 8'h61) && (ascii <= 8'h7A)) begin
            ascii = ascii - 8'h20;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines,
// deframes 11-bit frames, decodes make/break/shift and buffers ASCII in a
// first-word-fall-through FIFO read by the memory control unit (KBDR/KBSR).
module ps2_keyboard_rx
    import elc3_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic        KeyRead,
    output logic [15:0] Data_FromKeyboard,
    output logic        KeyReady,
    output logic        Overflow,
    output logic        FrameError
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    logic [1:0]   clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic         filt_clk_q, filt_clk_d;
    logic         fall;
    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shreg_q, shreg_d;
    logic         par_q, par_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic         byte_valid;
    logic         frame_err_q, frame_err_d;
    logic         break_q, break_d, ext_q, ext_d, shift_q, shift_d;
    logic         push, map_valid;
    logic [7:0]   map_ascii;
    logic [7:0]   mem_q [FIFO_DEPTH];
    logic [7:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         pop, full, push_ok;

    ps2_scancode_to_ascii u_map (
        .scan_code (shreg_q),
        .shift     (shift_q),
        .valid     (map_valid),
        .ascii     (map_ascii)
    );

    // Two-flop synchronizers and the PS2_CLK stability filter; fall marks
    // the cycle the filtered clock goes 1->0.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], PS2_CLK};
        dat_sync_d = {dat_sync_q[0], PS2_DAT};
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        fall       = 1'b0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q[1];
                fall       = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Frame FSM: samples data on filtered falling edges, checks odd parity
    // and stop bit, and abandons a stalled frame after TIMEOUT idle cycles.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        to_cnt_d    = (state_q == FS_IDLE) ? '0 : to_cnt_q + 1'b1;
        byte_valid  = 1'b0;
        frame_err_d = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                FS_IDLE: begin
                    if (!dat_sync_q[1]) begin
                        state_d   = FS_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                FS_DATA: begin
                    shreg_d   = {dat_sync_q[1], shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = FS_PARITY;
                end
                FS_PARITY: begin
                    par_d   = dat_sync_q[1];
                    state_d = FS_STOP;
                end
                FS_STOP: begin
                    state_d = FS_IDLE;
                    if (dat_sync_q[1] && (^{shreg_q, par_q})) byte_valid  = 1'b1;
                    else                                       frame_err_d = 1'b1;
                end
                default: state_d = FS_IDLE;
            endcase
        end else if ((state_q != FS_IDLE) && (to_cnt_q == TCW'(TIMEOUT - 1))) begin
            state_d  = FS_IDLE;
            to_cnt_d = '0;
        end
    end

    // Prefix/shift decoder: decides whether the received byte yields a character.
    always_comb begin
        break_d = break_q;
        ext_d   = ext_q;
        shift_d = shift_q;
        push    = 1'b0;
        if (byte_valid) begin
            if (shreg_q == SC_BREAK) begin
                break_d = 1'b1;
            end else if (shreg_q == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                break_d = 1'b0;
                ext_d   = 1'b0;
                if (is_shift(shreg_q)) shift_d = !break_q;
                else if (!break_q && !ext_q && map_valid) push = 1'b1;
            end
        end
    end

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so push+pop
    // always both succeed; a push into a full FIFO without pop is dropped.
    always_comb begin
        pop      = KeyRead && (count_q != '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        push_ok  = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push && full && !pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = map_ascii;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            state_q     <= FS_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
            ext_q       <= 1'b0;
            shift_q     <= 1'b0;
            mem_q       <= '{default: 8'h00};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_clk_q  <= filt_clk_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
            ext_q       <= ext_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign KeyReady          = (count_q != '0);
    assign Data_FromKeyboard = KeyReady ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
    assign Overflow          = ovf_q;
    assign FrameError        = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: a keyboard-side frame driver, a
// character-level reference model (expected FIFO queue, shift/prefix flags,
// overflow, frame-error count) checked every cycle, plus literal checkpoints.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int FIFO_DEPTH = 8;
    localparam int HALF       = 30;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic        KeyRead = 1'b0;
    logic [15:0] Data_FromKeyboard;
    logic        KeyReady, Overflow, FrameError;

    ps2_keyboard_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .PS2_CLK           (PS2_CLK),
        .PS2_DAT           (PS2_DAT),
        .KeyRead           (KeyRead),
        .Data_FromKeyboard (Data_FromKeyboard),
        .KeyReady          (KeyReady),
        .Overflow          (Overflow),
        .FrameError        (FrameError)
    );

    // Clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          check_en = 1'b0;
    int          fe_seen = 0;
    int          exp_fe = 0;
    int          lat_meas = FILTER_LEN + 2;
    logic [7:0]  exp_q[$];
    bit          m_shift = 1'b0, m_brk = 1'b0, m_ext = 1'b0, m_ovf = 1'b0;
    logic [17:0] cyc_exp;

    logic [7:0] sc_letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] sc_digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Character a key press should produce, from the key tables.
    task automatic model_lookup(input logic [7:0] sc, input bit sh, output bit ok, output logic [7:0] ch);
        ok = 1'b0;
        ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (sc == sc_letters[i]) begin ok = 1'b1; ch = (sh ? 8'h41 : 8'h61) + 8'(i); end
        for (int i = 0; i < 10; i++)
            if (sc == sc_digits[i]) begin ok = 1'b1; ch = 8'h30 + 8'(i); end
        if (sc == 8'h29) begin ok = 1'b1; ch = 8'h20; end
        if (sc == 8'h5A) begin ok = 1'b1; ch = 8'h0D; end
        if (sc == 8'h66) begin ok = 1'b1; ch = 8'h08; end
    endtask

    // Apply one accepted byte to the model.
    task automatic model_byte(input logic [7:0] b);
        bit ok;
        logic [7:0] ch;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
            else if (!m_brk && !m_ext) begin
                model_lookup(b, m_shift, ok, ch);
                if (ok) begin
                    if (exp_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
                    else exp_q.push_back(ch);
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // Per-cycle compare of outputs against the model, plus FrameError pulse count.
    always @(posedge Clk) begin
        #2;
        if (FrameError === 1'b1) fe_seen++;
        if (check_en) begin
            cyc_exp = {(exp_q.size() != 0) ? {8'h00, exp_q[0]} : 16'h0000,
                       exp_q.size() != 0, m_ovf};
            check("cycle_outputs", {14'd0, Data_FromKeyboard, KeyReady, Overflow}, {14'd0, cyc_exp});
        end
    end

    // Driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic ps2_bit(input logic v);
        @(negedge Clk);
        PS2_DAT = v;
        wait_cyc(HALF);
        PS2_CLK = 1'b0;
        wait_cyc(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 1; i < nbits; i++) ps2_bit(i[0]);
        wait_cyc(HALF);
    endtask

    // Full 11-bit frame; optionally measures KeyReady latency after the stop
    // bit, or pulses KeyRead on the rd_at-th clock after the stop-bit edge.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit meas, input int rd_at);
        logic [10:0] bits;
        logic p;
        int lat;
        bit seen;
        p = bad_par ? ^b : ~^b;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        @(negedge Clk);
        PS2_DAT = 1'b1;
        wait_cyc(HALF);
        check_en = 1'b0;
        PS2_CLK = 1'b0;
        if (meas) begin
            lat = 0;
            seen = 1'b0;
            while (!seen && lat < FILTER_LEN + 20) begin
                @(posedge Clk);
                #2;
                lat++;
                seen = KeyReady;
            end
            lat_meas = lat;
            check("keyready_latency_within_bound", {31'd0, seen && (lat <= FILTER_LEN + 5)}, 32'd1);
        end
        if (rd_at > 0) begin
            repeat (rd_at - 1) @(posedge Clk);
            @(negedge Clk);
            KeyRead = 1'b1;
            @(posedge Clk);
            @(negedge Clk);
            KeyRead = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        wait_cyc(HALF);
        if (bad_par) exp_fe++;
        else model_byte(b);
        check_en = 1'b1;
        PS2_CLK = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic key_read();
        @(negedge Clk);
        KeyRead = 1'b1;
        @(posedge Clk);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge Clk);
        KeyRead = 1'b0;
    endtask

    logic [7:0] seq2[7]  = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    logic [7:0] seq5[14] = '{8'h45, 8'h16, 8'h5A, 8'h66, 8'hE0, 8'h1C, 8'hF0, 8'h45,
                             8'h00, 8'h12, 8'h46, 8'hF0, 8'h12, 8'h2C};
    logic [7:0] drain6[8] = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6A};
    int fe_base;

    initial begin
        // Reset state
        wait_cyc(3);
        Reset = 1'b0;
        check("reset_data", {16'd0, Data_FromKeyboard}, 32'h0);
        check("reset_keyready", {31'd0, KeyReady}, 32'h0);
        check("reset_overflow", {31'd0, Overflow}, 32'h0);
        check("reset_frameerror", {31'd0, FrameError}, 32'h0);
        check_en = 1'b1;
        wait_cyc(5);

        // Single 'a' and read-back
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check("t1_data", {16'd0, Data_FromKeyboard}, 32'h0061);
        check("t1_ready", {31'd0, KeyReady}, 32'h1);
        key_read();
        check("t1_after_read", {15'd0, KeyReady, Data_FromKeyboard}, 32'h0);

        // Shift make/break around 'a'
        for (int i = 0; i < 7; i++) send_frame(seq2[i], 1'b0, 1'b0, 0);
        check("t2_first", {16'd0, Data_FromKeyboard}, 32'h0041);
        key_read();
        check("t2_second", {16'd0, Data_FromKeyboard}, 32'h0061);
        key_read();
        check("t2_empty", {31'd0, KeyReady}, 32'h0);

        // Bad parity
        fe_base = fe_seen;
        send_frame(8'h1C, 1'b1, 1'b0, 0);
        check("t3_fe_pulse_cycles", fe_seen - fe_base, 32'd1);
        check("t3_ready", {31'd0, KeyReady}, 32'h0);

        // Stalled partial frame then space
        send_partial(5);
        wait_cyc(TIMEOUT + 100);
        send_frame(8'h29, 1'b0, 1'b0, 0);
        check("t4_space", {16'd0, Data_FromKeyboard}, 32'h0020);
        check("t4_fe_total", fe_seen, exp_fe);
        key_read();

        // Digits, enter, backspace, ext/break/unmapped discards, shifted digit
        for (int i = 0; i < 14; i++) send_frame(seq5[i], 1'b0, 1'b0, 0);
        check("t5_head", {16'd0, Data_FromKeyboard}, 32'h0030);
        check("t5_depth", exp_q.size(), 32'd6);
        while (exp_q.size() != 0) key_read();
        check("t5_empty", {31'd0, KeyReady}, 32'h0);

        // Overflow with 9 letters, then push+pop on a full FIFO
        for (int i = 0; i < 9; i++) send_frame(sc_letters[i], 1'b0, 1'b0, 0);
        check("t6_overflow", {31'd0, Overflow}, 32'h1);
        check("t6_head", {16'd0, Data_FromKeyboard}, 32'h0061);
        send_frame(8'h3B, 1'b0, 1'b0, lat_meas);
        check("t6_head_after_pushpop", {16'd0, Data_FromKeyboard}, 32'h0062);
        check("t6_overflow_sticky", {31'd0, Overflow}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            check("t6_drain", {16'd0, Data_FromKeyboard}, {24'd0, drain6[i]});
            key_read();
        end
        check("t6_empty", {31'd0, KeyReady}, 32'h0);

        // Reset mid-frame with characters queued
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        send_frame(8'h32, 1'b0, 1'b0, 0);
        send_frame(8'h21, 1'b0, 1'b0, 0);
        send_partial(4);
        @(negedge Clk);
        check_en = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        exp_q.delete();
        m_shift = 1'b0; m_brk = 1'b0; m_ext = 1'b0; m_ovf = 1'b0;
        check("t7_data", {16'd0, Data_FromKeyboard}, 32'h0);
        check("t7_ready", {31'd0, KeyReady}, 32'h0);
        check("t7_overflow", {31'd0, Overflow}, 32'h0);
        check("t7_frameerror", {31'd0, FrameError}, 32'h0);
        check_en = 1'b1;
        wait_cyc(HALF);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        check("t7_enter", {16'd0, Data_FromKeyboard}, 32'h000D);
        check("final_fe_total", fe_seen, exp_fe);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, meaning Clk cycles PS2_CLK must stay stable before its filtered level changes.
REQ-002 Parameter TIMEOUT, default 50000, meaning Clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, meaning number of buffered characters.
REQ-004 Clk  input  1  system clock (CLOCK_50); one clock domain; every register SHALL be clocked on its rising edge.
REQ-005 Reset  input  1  reset; synchronous and active-high.
REQ-006 PS2_CLK  input  1  raw PS/2 clock from the keyboard; asynchronous.
REQ-007 PS2_DAT  input  1  raw PS/2 data from the keyboard; asynchronous.
REQ-008 KeyRead  input  1  one-cycle pop request from the memory control unit (KBDR read).
REQ-009 Data_FromKeyboard  output  16  {8'h00, ASCII at FIFO head}; 16'h0000 when FIFO empty.
REQ-010 KeyReady  output  1  FIFO non-empty (KBSR[15]).
REQ-011 Overflow  output  1  sticky: a character was dropped because the FIFO was full.
REQ-012 FrameError  output  1  one-cycle pulse per rejected frame.

Function
REQ-013 PS2_CLK and PS2_DAT SHALL each pass through a two-flop synchronizer before use.
REQ-014 Filtered PS2_CLK SHALL change only after the synchronized value has differed from it for FILTER_LEN consecutive cycles.
REQ-015 Data SHALL be sampled on each 1->0 transition of filtered PS2_CLK; no other edge advances the frame FSM.
REQ-016 Frame FSM states: IDLE, DATA, PARITY, STOP; DATA receives 8 bits LSB first.
REQ-017 IDLE->DATA on a sample of 0; a sample of 1 in IDLE is ignored.
REQ-018 After STOP, the FSM SHALL return to IDLE; a frame is accepted only if parity is odd over data+parity and stop = 1, otherwise FrameError pulses and the byte is discarded.
REQ-019 In any non-IDLE state, TIMEOUT cycles with no sample SHALL force IDLE with no FrameError and no byte.
REQ-020 Decoder: 0xF0 sets break flag, 0xE0 sets ext flag; the next non-prefix byte clears both and is then processed.
REQ-021 Make/break of 0x12 or 0x59 SHALL set/clear the shift flag; shift codes never enter the FIFO.
REQ-022 A non-break, non-ext byte with a mapping SHALL push its ASCII: 0x1C..letters -> 'a'-'z' ('A'-'Z' while shift set), digit row -> '0'-'9', 0x29->0x20, 0x5A->0x0D, 0x66->0x08; unmapped, break, or ext bytes are discarded.
REQ-023 KeyReady SHALL assert no later than 3 Clk cycles after the filtered falling edge sampling the stop bit.
REQ-024 FIFO is first-word fall-through; KeyRead pops the head at the next edge; KeyRead when empty is ignored.
REQ-025 Push while full (without pop) SHALL drop the new character and set Overflow; simultaneous push and pop SHALL both succeed at any occupancy, occupancy unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy count SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-027 While Reset is high at a Clk edge: FSM->IDLE, shift/break/ext flags cleared, FIFO emptied, filter and timeout counters cleared, filtered PS2_CLK set to 1.
REQ-028 After reset: Data_FromKeyboard=16'h0000, KeyReady=0, Overflow=0, FrameError=0; a frame in progress at reset is discarded.

Structure
REQ-029 Package elc3_kbd_pkg SHALL hold the frame-state enum and constants SC_BREAK=0xF0, SC_EXT=0xE0, SC_LSHIFT=0x12, SC_RSHIFT=0x59.
REQ-030 Sub-module ps2_scancode_to_ascii SHALL be a purely combinational lookup (scan code, shift -> valid, ASCII).

Verification
REQ-031 Frame 0x1C, correct parity -> KeyReady=1, Data_FromKeyboard=16'h0061; KeyRead pulse -> KeyReady=0, data 16'h0000.
REQ-032 Frames 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C -> FIFO holds 0x41 then 0x61 only.
REQ-033 Frame 0x1C with even parity -> one FrameError pulse, KeyReady stays 0.
REQ-034 9 mapped make codes, no reads -> 8 characters buffered, Overflow=1; push+KeyRead same cycle when full -> count stays 8, order preserved.
REQ-035 Start bit plus 4 data bits then silence > TIMEOUT, then frame 0x29 -> Data_FromKeyboard=16'h0020, no FrameError.
REQ-036 Reset asserted mid-frame with 3 characters queued -> all outputs 0 next cycle; following frame 0x5A -> 16'h000D.
